seg_scan_ctrl: RTL

Time-multiplexed scan controller for an 8-digit common-anode seven-segment display. Sits directly upstream of the 3-to-8 active-low digit decoder. Drives the decoder's enable and select inputs in rotation and presents the matching active-low segment pattern for each digit of a 32-bit hex value. Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seg_scan_ctrl_pkg.sv | 20 ++
 rtl/seg_scan_ctrl_if.sv | 21 ++
 rtl/seg_scan_ctrl_hex7seg.sv | 9 +
 rtl/seg_scan_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [2:0] DEC_ON    = 3'b001;
  localparam logic [2:0] DEC_OFF   = 3'b000;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-high {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] HEXSEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle: scan controls and frame inputs in, decoder/segment drive out.
interface seg_scan_ctrl_if;
  logic        enable;
  logic [31:0] data;
  logic [7:0]  digit_mask;
  logic [7:0]  dp_mask;
  logic [2:0]  dec_en;
  logic [2:0]  dec_in;
  logic [7:0]  seg_n;
  logic        frame_start;

  modport master (
    output enable, data, digit_mask, dp_mask,
    input  dec_en, dec_in, seg_n, frame_start
  );

  modport slave (
    input  enable, data, digit_mask, dp_mask,
    output dec_en, dec_in, seg_n, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb seg_o = HEXSEG[nib_i];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed scan controller with per-slot blanking and frame-latched inputs.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_scan_ctrl_if.slave scan
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic [7:0]       dmask_q, dmask_d;
  logic [7:0]       dpmask_q, dpmask_d;

  logic [2:0] dec_en_q, dec_en_d;
  logic [2:0] dec_in_q, dec_in_d;
  logic [7:0] seg_n_q, seg_n_d;
  logic       frame_q, frame_d;
  logic       frame_entry;
  logic [3:0] nib;
  logic [6:0] hex_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      dmask_q  <= '0;
      dpmask_q <= '0;
      dec_en_q <= DEC_OFF;
      dec_in_q <= '0;
      seg_n_q  <= SEG_BLANK;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      dmask_q  <= dmask_d;
      dpmask_q <= dpmask_d;
      dec_en_q <= dec_en_d;
      dec_in_q <= dec_in_d;
      seg_n_q  <= seg_n_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!scan.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = '0;
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    frame_entry = (state_d == SHOW) && (state_q != SHOW) && (idx_d == 3'd0);
    data_d   = frame_entry ? scan.data       : data_q;
    dmask_d  = frame_entry ? scan.digit_mask : dmask_q;
    dpmask_d = frame_entry ? scan.dp_mask    : dpmask_q;
    nib      = data_d[4*int'(idx_d) +: 4];

    dec_en_d = DEC_OFF;
    seg_n_d  = SEG_BLANK;
    dec_in_d = idx_d;
    frame_d  = frame_entry;
    if (state_d == SHOW) begin
      dec_en_d = dmask_d[idx_d] ? DEC_ON : DEC_OFF;
      seg_n_d  = ~{dpmask_d[idx_d], hex_seg};
    end
  end

  hex7seg u_hex7seg (
    .nib_i (nib),
    .seg_o (hex_seg)
  );

  assign scan.dec_en      = dec_en_q;
  assign scan.dec_in      = dec_in_q;
  assign scan.seg_n       = seg_n_q;
  assign scan.frame_start = frame_q;

endmodule
